// File: rtl/frame_bank_pkg.sv
// Shared definitions for the frame bank scheduler.
// Contains the FSM state encodings, the bank index type and the bank
// assignment that applies after reset.
package frame_bank_pkg;

    localparam int BANK_W = 2;

    typedef logic [BANK_W-1:0] bank_t;

    // Bank roles after reset: camera writes 0, 1 is ready, display reads 2
    localparam bank_t WR0  = 2'd0;
    localparam bank_t RDY0 = 2'd1;
    localparam bank_t RD0  = 2'd2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        WAIT_SOF = 3'd2,
        CAPTURE  = 3'd3,
        HOLD     = 3'd4
    } state_t;

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// Signal bundle between the scheduler and the logic around it.
// The master side drives the camera VSYNC, the VGA frame-start pulse and the
// capture controls. The slave side (the scheduler) returns the RAM write
// gate, the bank selects, the frame_valid flag, the FSM state and the
// statistics counters.
interface frame_bank_scheduler_if #(
    parameter int CNT_W = 16
);
    import frame_bank_pkg::*;

    logic             VSYNC_cam;
    logic             vga_sof;
    logic             capture_en;
    logic             snap_mode;
    logic             snap_req;
    logic             wr_en;
    bank_t            wr_bank;
    bank_t            rd_bank;
    logic             frame_valid;
    logic [2:0]       state;
    logic [CNT_W-1:0] cap_count;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output VSYNC_cam, vga_sof, capture_en, snap_mode, snap_req,
        input  wr_en, wr_bank, rd_bank, frame_valid, state, cap_count, drop_count
    );

    modport slave (
        input  VSYNC_cam, vga_sof, capture_en, snap_mode, snap_req,
        output wr_en, wr_bank, rd_bank, frame_valid, state, cap_count, drop_count
    );

endinterface

// File: rtl/vsync_edge_sync.sv
// Brings the raw camera VSYNC into the clk25 domain and detects its edges.
// Ports:
//   clk25, rst : clock, async active-high reset
//   vsync_raw  : camera VSYNC (high = inter-frame blanking)
//   sof_ev     : one-cycle pulse on a falling edge (camera frame start)
//   eof_ev     : one-cycle pulse on a rising edge (camera frame end)
// SYNC_STAGES must be at least 2.
module vsync_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk25,
    input  logic rst,
    input  logic vsync_raw,
    output logic sof_ev,
    output logic eof_ev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Flops reset high so that leaving reset during blanking creates no edge
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vsync_raw};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sof_ev = edge_q & ~sync_q[SYNC_STAGES-1];
    assign eof_ev = ~edge_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler for the camera frame RAM.
// The camera writes to wr_bank and the display reads from rd_bank. A
// finished camera frame becomes the "ready" bank. The ready bank is handed
// to the display only on vga_sof, so the display never shows a torn frame.
// Ports:
//   clk25, rst : clock, async active-high reset
//   bus        : slave side of frame_bank_scheduler_if
// Build option: FRAME_BANK_STATS_EN enables cap_count/drop_count. When it
// is not defined, both outputs are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | capture disabled, RAM writes gated off
// SETTLE   | discarding SETTLE_FRAMES frames after capture starts
// WAIT_SOF | waiting for the next camera frame start
// CAPTURE  | writing the current camera frame into wr_bank
// HOLD     | snapshot taken, waiting for snap_req or continuous mode
module frame_bank_scheduler
    import frame_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_FRAMES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                   clk25,
    input  logic                   rst,
    frame_bank_scheduler_if.slave  bus
);

    localparam int SW = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

    logic          sof_ev, eof_ev;
    state_t        state_q, state_next;
    logic [SW-1:0] settle_q, settle_next;
    logic          wr_en_q;
    bank_t         wr_q, rdy_q, rd_q;
    logic          pending_q, valid_q;
    logic          publish, swap;

    vsync_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clk25     (clk25),
        .rst       (rst),
        .vsync_raw (bus.VSYNC_cam),
        .sof_ev    (sof_ev),
        .eof_ev    (eof_ev)
    );

    always_comb begin
        state_next  = state_q;
        settle_next = settle_q;
        publish     = 1'b0;
        if (!bus.capture_en) begin
            // Abort wins over a same-cycle eof_ev, so no partial publish
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    settle_next = SW'(SETTLE_FRAMES);
                    state_next  = (SETTLE_FRAMES == 0) ? WAIT_SOF : SETTLE;
                end
                SETTLE: if (eof_ev) begin
                    settle_next = settle_q - SW'(1);
                    if (settle_q <= SW'(1))
                        state_next = WAIT_SOF;
                end
                WAIT_SOF: if (sof_ev) state_next = CAPTURE;
                CAPTURE: if (eof_ev) begin
                    publish    = 1'b1;
                    state_next = bus.snap_mode ? HOLD : WAIT_SOF;
                end
                HOLD: if (bus.snap_req || !bus.snap_mode) state_next = WAIT_SOF;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_next;
            settle_q <= settle_next;
            wr_en_q  <= (state_next == CAPTURE);
        end
    end

    assign swap = bus.vga_sof & pending_q;

    // Three-way rotation when a publish and a display swap land together
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            wr_q      <= WR0;
            rdy_q     <= RDY0;
            rd_q      <= RD0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (publish && swap) begin
            wr_q    <= rd_q;
            rdy_q   <= wr_q;
            rd_q    <= rdy_q;
            valid_q <= 1'b1;
        end else if (publish) begin
            wr_q      <= rdy_q;
            rdy_q     <= wr_q;
            pending_q <= 1'b1;
        end else if (swap) begin
            rd_q      <= rdy_q;
            rdy_q     <= rd_q;
            pending_q <= 1'b0;
            valid_q   <= 1'b1;
        end
    end

`ifdef FRAME_BANK_STATS_EN
    logic [CNT_W-1:0] cap_q, drop_q;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            drop_q <= '0;
        end else if (publish) begin
            if (cap_q != '1)
                cap_q <= cap_q + CNT_W'(1);
            // An unshown ready frame is overwritten only when no swap takes it
            if (pending_q && !swap && drop_q != '1)
                drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign bus.cap_count  = cap_q;
    assign bus.drop_count = drop_q;
`else
    assign bus.cap_count  = {CNT_W{1'b0}};
    assign bus.drop_count = {CNT_W{1'b0}};
`endif

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_bank     = wr_q;
    assign bus.rd_bank     = rd_q;
    assign bus.frame_valid = valid_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
module tb_frame_bank_scheduler;

`ifdef FRAME_BANK_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] exp_c;

    frame_bank_scheduler_if #(.CNT_W(16)) bus ();

    frame_bank_scheduler #(.SYNC_STAGES(2), .SETTLE_FRAMES(2), .CNT_W(16)) dut (
        .clk25 (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bank selects must always be two distinct members of {0,1,2}
    always @(negedge clk) begin
        checks++;
        if (bus.wr_bank > 2'd2 || bus.rd_bank > 2'd2 || bus.wr_bank == bus.rd_bank) begin
            failures++;
            $display("FAIL perm wr=%0d rd=%0d exp distinct in 0..2", bus.wr_bank, bus.rd_bank);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        bus.VSYNC_cam = 1'b0;
        tick(5);
        bus.VSYNC_cam = 1'b1;
        tick(5);
    endtask

    task automatic pulse_sof();
        bus.vga_sof = 1'b1;
        tick(1);
        bus.vga_sof = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.VSYNC_cam  = 1'b1;
        bus.vga_sof    = 1'b0;
        bus.capture_en = 1'b0;
        bus.snap_mode  = 1'b0;
        bus.snap_req   = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd2 ||
            bus.frame_valid !== 1'b0 || bus.state !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs wr_en=%0d wr=%0d rd=%0d fv=%0d st=%0d exp 0 0 2 0 0",
                     bus.wr_en, bus.wr_bank, bus.rd_bank, bus.frame_valid, bus.state);
        end
        checks++;
        if (bus.cap_count !== 16'd0 || bus.drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters cap=%0d drop=%0d exp 0 0", bus.cap_count, bus.drop_count);
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if (bus.state !== 3'd0 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold st=%0d wr_en=%0d exp 0 0", bus.state, bus.wr_en);
        end
    endtask

    task automatic test_settle_capture();
        do_reset();
        bus.capture_en = 1'b1;
        tick(1);
        checks++;
        if (bus.state !== 3'd1) begin
            failures++;
            $display("FAIL enter_settle st=%0d exp 1", bus.state);
        end
        frame();
        checks++;
        if (bus.state !== 3'd1 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL settle_1 st=%0d wr_en=%0d exp 1 0", bus.state, bus.wr_en);
        end
        frame();
        checks++;
        if (bus.state !== 3'd2 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL settle_done st=%0d wr_en=%0d exp 2 0", bus.state, bus.wr_en);
        end
        bus.VSYNC_cam = 1'b0;
        tick(2);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_en_early got=%0d exp 0", bus.wr_en);
        end
        tick(1);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.state !== 3'd3) begin
            failures++;
            $display("FAIL wr_en_rise wr_en=%0d st=%0d exp 1 3", bus.wr_en, bus.state);
        end
        tick(2);
        bus.VSYNC_cam = 1'b1;
        tick(3);
        exp_c = STATS_ON ? 16'd1 : 16'd0;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.state !== 3'd2 || bus.wr_bank !== 2'd1 ||
            bus.rd_bank !== 2'd2 || bus.frame_valid !== 1'b0 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL publish_1 wr_en=%0d st=%0d wr=%0d rd=%0d fv=%0d cap=%0d exp 0 2 1 2 0 %0d",
                     bus.wr_en, bus.state, bus.wr_bank, bus.rd_bank, bus.frame_valid, bus.cap_count, exp_c);
        end
        // Display swap: ready (0) moves to rd, old rd (2) becomes ready
        pulse_sof();
        checks++;
        if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd1 || bus.frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL display_swap rd=%0d wr=%0d fv=%0d exp 0 1 1", bus.rd_bank, bus.wr_bank, bus.frame_valid);
        end
        pulse_sof();
        checks++;
        if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd1 || bus.frame_valid !== 1'b1) begin
            failures++;
            $display("FAIL sof_no_pending rd=%0d wr=%0d fv=%0d exp 0 1 1", bus.rd_bank, bus.wr_bank, bus.frame_valid);
        end
    endtask

    task automatic test_drop_and_simultaneous();
        do_reset();
        bus.capture_en = 1'b1;
        tick(1);
        frame();
        frame();
        frame();
        frame();
        exp_c = STATS_ON ? 16'd2 : 16'd0;
        checks++;
        if (bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd2 || bus.frame_valid !== 1'b0 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL drop_banks wr=%0d rd=%0d fv=%0d cap=%0d exp 0 2 0 %0d",
                     bus.wr_bank, bus.rd_bank, bus.frame_valid, bus.cap_count, exp_c);
        end
        exp_c = STATS_ON ? 16'd1 : 16'd0;
        checks++;
        if (bus.drop_count !== exp_c) begin
            failures++;
            $display("FAIL drop_count got=%0d exp %0d", bus.drop_count, exp_c);
        end
        // (wr,rdy,rd)=(0,1,2) with pending: publish and vga_sof land together
        bus.VSYNC_cam = 1'b0;
        tick(5);
        bus.VSYNC_cam = 1'b1;
        tick(2);
        pulse_sof();
        exp_c = STATS_ON ? 16'd3 : 16'd0;
        checks++;
        if (bus.wr_bank !== 2'd2 || bus.rd_bank !== 2'd1 || bus.frame_valid !== 1'b1 ||
            bus.state !== 3'd2 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL simul_rotate wr=%0d rd=%0d fv=%0d st=%0d cap=%0d exp 2 1 1 2 %0d",
                     bus.wr_bank, bus.rd_bank, bus.frame_valid, bus.state, bus.cap_count, exp_c);
        end
        exp_c = STATS_ON ? 16'd1 : 16'd0;
        checks++;
        if (bus.drop_count !== exp_c) begin
            failures++;
            $display("FAIL simul_no_drop got=%0d exp %0d", bus.drop_count, exp_c);
        end
        // pending must still be set: the next vga_sof takes ready bank 0
        tick(2);
        pulse_sof();
        checks++;
        if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd2) begin
            failures++;
            $display("FAIL simul_pending rd=%0d wr=%0d exp 0 2", bus.rd_bank, bus.wr_bank);
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        bus.snap_mode  = 1'b1;
        bus.capture_en = 1'b1;
        tick(1);
        frame();
        frame();
        frame();
        checks++;
        if (bus.state !== 3'd4 || bus.wr_bank !== 2'd1 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL snap_hold st=%0d wr=%0d wr_en=%0d exp 4 1 0", bus.state, bus.wr_bank, bus.wr_en);
        end
        for (int f = 0; f < 3; f++) begin
            bus.VSYNC_cam = 1'b0;
            tick(5);
            checks++;
            if (bus.wr_en !== 1'b0 || bus.state !== 3'd4) begin
                failures++;
                $display("FAIL hold_frame%0d wr_en=%0d st=%0d exp 0 4", f, bus.wr_en, bus.state);
            end
            bus.VSYNC_cam = 1'b1;
            tick(5);
        end
        checks++;
        if (bus.wr_bank !== 2'd1) begin
            failures++;
            $display("FAIL hold_banks wr=%0d exp 1", bus.wr_bank);
        end
        bus.snap_req = 1'b1;
        tick(1);
        bus.snap_req = 1'b0;
        checks++;
        if (bus.state !== 3'd2) begin
            failures++;
            $display("FAIL snap_rearm st=%0d exp 2", bus.state);
        end
        bus.VSYNC_cam = 1'b0;
        tick(5);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.state !== 3'd3) begin
            failures++;
            $display("FAIL snap_capture wr_en=%0d st=%0d exp 1 3", bus.wr_en, bus.state);
        end
        bus.VSYNC_cam = 1'b1;
        tick(5);
        exp_c = STATS_ON ? 16'd2 : 16'd0;
        checks++;
        if (bus.state !== 3'd4 || bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd2 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL snap_second st=%0d wr=%0d rd=%0d cap=%0d exp 4 0 2 %0d",
                     bus.state, bus.wr_bank, bus.rd_bank, bus.cap_count, exp_c);
        end
        frame();
        checks++;
        if (bus.state !== 3'd4 || bus.wr_bank !== 2'd0) begin
            failures++;
            $display("FAIL snap_only_one st=%0d wr=%0d exp 4 0", bus.state, bus.wr_bank);
        end
        bus.snap_mode = 1'b0;
        tick(1);
        checks++;
        if (bus.state !== 3'd2) begin
            failures++;
            $display("FAIL hold_to_cont st=%0d exp 2", bus.state);
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.capture_en = 1'b1;
        tick(1);
        frame();
        frame();
        frame();
        pulse_sof();
        // Now (wr,rdy,rd)=(1,2,0), frame_valid=1, one frame published
        bus.VSYNC_cam = 1'b0;
        tick(5);
        checks++;
        if (bus.wr_en !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre wr_en=%0d exp 1", bus.wr_en);
        end
        bus.capture_en = 1'b0;
        tick(1);
        exp_c = STATS_ON ? 16'd1 : 16'd0;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.state !== 3'd0 || bus.wr_bank !== 2'd1 ||
            bus.rd_bank !== 2'd0 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL abort_mid wr_en=%0d st=%0d wr=%0d rd=%0d cap=%0d exp 0 0 1 0 %0d",
                     bus.wr_en, bus.state, bus.wr_bank, bus.rd_bank, bus.cap_count, exp_c);
        end
        bus.VSYNC_cam = 1'b1;
        tick(5);
        checks++;
        if (bus.wr_bank !== 2'd1 || bus.state !== 3'd0) begin
            failures++;
            $display("FAIL abort_eof wr=%0d st=%0d exp 1 0", bus.wr_bank, bus.state);
        end
        bus.capture_en = 1'b1;
        tick(1);
        checks++;
        if (bus.state !== 3'd1) begin
            failures++;
            $display("FAIL rearm_settle st=%0d exp 1", bus.state);
        end
        frame();
        frame();
        bus.VSYNC_cam = 1'b0;
        tick(5);
        bus.VSYNC_cam = 1'b1;
        tick(2);
        bus.capture_en = 1'b0;
        tick(1);
        checks++;
        if (bus.state !== 3'd0 || bus.wr_en !== 1'b0 || bus.wr_bank !== 2'd1 || bus.cap_count !== exp_c) begin
            failures++;
            $display("FAIL abort_vs_eof st=%0d wr_en=%0d wr=%0d cap=%0d exp 0 0 1 %0d",
                     bus.state, bus.wr_en, bus.wr_bank, bus.cap_count, exp_c);
        end
        bus.capture_en = 1'b1;
        tick(1);
        frame();
        frame();
        bus.VSYNC_cam = 1'b0;
        tick(5);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd2 ||
            bus.frame_valid !== 1'b0 || bus.state !== 3'd0 || bus.cap_count !== 16'd0) begin
            failures++;
            $display("FAIL async_rst wr_en=%0d wr=%0d rd=%0d fv=%0d st=%0d cap=%0d exp 0 0 2 0 0 0",
                     bus.wr_en, bus.wr_bank, bus.rd_bank, bus.frame_valid, bus.state, bus.cap_count);
        end
        bus.VSYNC_cam = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_settle_capture();
        test_drop_and_simultaneous();
        test_snapshot();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
